// File: rtl/shared_dff_arbiter_pkg.sv
// Shared types and constants for the shared-register round-robin arbiter.
package shared_dff_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_dff_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~exclude)
// scanning upward from ptr, wrapping modulo NREQ.
module shared_dff_arbiter_rr_pick
    import shared_dff_arbiter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] exclude,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [NREQ-1:0] cand;
    logic [IW-1:0]   idx;

    assign cand = req & ~exclude;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!valid && cand[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_dff_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between NREQ requesters,
// with an optional bounded lock for the current owner.
module shared_dff_arbiter
    import shared_dff_arbiter_pkg::*;
#(
    parameter  int NREQ     = DEF_NREQ,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IW       = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [IW-1:0]         owner,
    output logic                  busy,
    output logic                  upd,
    output logic [WIDTH-1:0]      q
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              upd_q, upd_d;

    logic              in_grant;
    logic [IW-1:0]     owner_next_ptr;
    logic [NREQ-1:0]   owner_oh;
    logic              owner_req, owner_lock, hold_more;
    logic [WIDTH-1:0]  owner_data;
    logic [IW-1:0]     pick_ptr, pick_winner;
    logic [NREQ-1:0]   pick_excl;
    logic              pick_valid;

    assign in_grant       = (state_q == GRANT);
    assign owner_next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_oh       = NREQ'(1) << owner_q;
    assign owner_req      = req[owner_q];
    assign owner_lock     = lock[owner_q];
    assign owner_data     = wdata[int'(owner_q)*WIDTH +: WIDTH];
    assign hold_more      = (hold_q < HW'(MAX_HOLD - 1));

    // On release the search starts past the outgoing owner and skips it, so
    // it only wins back the register when nobody else is asking.
    assign pick_ptr  = in_grant ? owner_next_ptr : rr_ptr_q;
    assign pick_excl = in_grant ? owner_oh : '0;

    shared_dff_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        upd_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick_winner;
                    owner_d = pick_winner;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    q_d   = owner_data;
                    upd_d = 1'b1;
                end
                if (owner_req && owner_lock && hold_more) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    rr_ptr_d = owner_next_ptr;
                    hold_d   = '0;
                    if (pick_valid) begin
                        gnt_d   = NREQ'(1) << pick_winner;
                        owner_d = pick_winner;
                    end else if (!owner_req) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            upd_q    <= upd_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = in_grant;
    assign upd   = upd_q;
    assign q     = q_q;

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// Directed bench for shared_dff_arbiter: vector table plus hand-written
// abort and reset-during-grant sequences.
module tb_shared_dff_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        upd;
    logic [7:0]  q;

    int n_cmp = 0;
    int n_bad = 0;

    shared_dff_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .upd   (upd),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        busy;
        logic        upd;
        logic [7:0]  q;
    } vec_t;

    localparam logic [31:0] D_ROT = 32'h1312_1110;  // lane i = 8'h10 + i

    vec_t tbl [18];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                input logic [31:0] wd, input logic [3:0] g, input logic [1:0] o,
                                input logic b, input logic u, input logic [7:0] qq);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.wdata = wd;
        v.gnt = g; v.owner = o; v.busy = b; v.upd = u; v.q = qq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                         input logic [31:0] wd);
        rst = r; req = rq; lock = lk; wdata = wd;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic u, input logic [7:0] qq);
        check({tag, ".gnt"},   32'(gnt),   32'(g));
        check({tag, ".owner"}, 32'(owner), 32'(o));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".upd"},   32'(upd),   32'(u));
        check({tag, ".q"},     32'(q),     32'(qq));
    endtask

    initial begin
        // Each row: inputs held across one rising edge, outputs checked after it.
        // Single write; a level request still high in its grant cycle is re-granted.
        tbl[0]  = mk(0, 4'b0001, 4'b0000, 32'h0000_00A5, 4'b0001, 2'd0, 1, 0, 8'h00);
        tbl[1]  = mk(0, 4'b0001, 4'b0000, 32'h0000_00A5, 4'b0001, 2'd0, 1, 1, 8'hA5);
        tbl[2]  = mk(0, 4'b0000, 4'b0000, 32'h0000_00A5, 4'b0000, 2'd0, 0, 0, 8'hA5);
        // Contention: rotation 0,1,2,3,0 with no idle cycles.
        tbl[3]  = mk(1, 4'b0000, 4'b0000, D_ROT,         4'b0000, 2'd0, 0, 0, 8'h00);
        tbl[4]  = mk(0, 4'b1111, 4'b0000, D_ROT,         4'b0001, 2'd0, 1, 0, 8'h00);
        tbl[5]  = mk(0, 4'b1111, 4'b0000, D_ROT,         4'b0010, 2'd1, 1, 1, 8'h10);
        tbl[6]  = mk(0, 4'b1111, 4'b0000, D_ROT,         4'b0100, 2'd2, 1, 1, 8'h11);
        tbl[7]  = mk(0, 4'b1111, 4'b0000, D_ROT,         4'b1000, 2'd3, 1, 1, 8'h12);
        tbl[8]  = mk(0, 4'b1111, 4'b0000, D_ROT,         4'b0001, 2'd0, 1, 1, 8'h13);
        tbl[9]  = mk(0, 4'b0000, 4'b0000, D_ROT,         4'b0000, 2'd0, 0, 0, 8'h13);
        // Lock held by 0: four grant cycles, then forced over to 1.
        tbl[10] = mk(1, 4'b0000, 4'b0000, D_ROT,         4'b0000, 2'd0, 0, 0, 8'h00);
        tbl[11] = mk(0, 4'b0011, 4'b0001, D_ROT,         4'b0001, 2'd0, 1, 0, 8'h00);
        tbl[12] = mk(0, 4'b0011, 4'b0001, D_ROT,         4'b0001, 2'd0, 1, 1, 8'h10);
        tbl[13] = mk(0, 4'b0011, 4'b0001, D_ROT,         4'b0001, 2'd0, 1, 1, 8'h10);
        tbl[14] = mk(0, 4'b0011, 4'b0001, D_ROT,         4'b0001, 2'd0, 1, 1, 8'h10);
        tbl[15] = mk(0, 4'b0011, 4'b0001, D_ROT,         4'b0010, 2'd1, 1, 1, 8'h10);
        // lock[0] is ignored while 1 owns; 1 releases after one write.
        tbl[16] = mk(0, 4'b0011, 4'b0001, D_ROT,         4'b0001, 2'd0, 1, 1, 8'h11);
        tbl[17] = mk(0, 4'b0000, 4'b0000, D_ROT,         4'b0000, 2'd0, 0, 0, 8'h11);

        // Reset, then idle.
        drive(1, 4'b0000, 4'b0000, 32'h0);
        tick();
        tick();
        check_all("reset", 4'b0000, 2'd0, 0, 0, 8'h00);
        drive(0, 4'b0000, 4'b0000, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all($sformatf("idle%0d", i), 4'b0000, 2'd0, 0, 0, 8'h00);
        end

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].wdata);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].owner,
                      tbl[i].busy, tbl[i].upd, tbl[i].q);
        end

        // Abort: rr_ptr is 1 here; requester 2 wins, then drops req in its grant cycle.
        drive(0, 4'b0100, 4'b0000, 32'h0077_0000);
        tick();
        check_all("abort.gnt", 4'b0100, 2'd2, 1, 0, 8'h11);
        drive(0, 4'b0000, 4'b0000, 32'h0077_0000);
        tick();
        check_all("abort.drop", 4'b0000, 2'd2, 0, 0, 8'h11);
        tick();
        check_all("abort.idle", 4'b0000, 2'd2, 0, 0, 8'h11);

        // Reset during requester 1's grant with 8'h33 pending (rr_ptr is 3).
        drive(0, 4'b0010, 4'b0000, 32'h0000_3300);
        tick();
        check_all("rstmid.gnt", 4'b0010, 2'd1, 1, 0, 8'h11);
        drive(1, 4'b0010, 4'b0000, 32'h0000_3300);
        tick();
        check_all("rstmid.rst", 4'b0000, 2'd0, 0, 0, 8'h00);
        // Arbitration restarts at rr_ptr 0, so requester 0 wins over 1..3.
        drive(0, 4'b1111, 4'b0000, D_ROT);
        tick();
        check_all("rstmid.rearb", 4'b0001, 2'd0, 1, 0, 8'h00);
        tick();
        check_all("rstmid.next", 4'b0010, 2'd1, 1, 1, 8'h10);

        drive(0, 4'b0000, 4'b0000, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
